// File: rtl/sf2_pipe.sv
// ============================================================================
// sf2_pipe : pipelined word/halfword rotate and shift-left unit (big-endian lanes)
// Rev 1.0
// ============================================================================
`default_nettype none

module sf2_pipe #(
    parameter int WIDTH   = 128,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:31]        instruction,
    input  logic [0:WIDTH-1]   RA_data_in,
    input  logic [0:WIDTH-1]   RB_data_in,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:WIDTH-1]   RT_data_out,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_illegal
);

    localparam int NW = WIDTH / 32;
    localparam int NH = WIDTH / 16;

    localparam logic [10:0] OP_ROT   = 11'b00001011000;
    localparam logic [10:0] OP_ROTI  = 11'b00001111000;
    localparam logic [10:0] OP_SHL   = 11'b00001011011;
    localparam logic [10:0] OP_SHLI  = 11'b00001111011;
    localparam logic [10:0] OP_ROTH  = 11'b00001011100;
    localparam logic [10:0] OP_ROTHI = 11'b00001111100;
    localparam logic [10:0] OP_SHLH  = 11'b00001011111;
    localparam logic [10:0] OP_SHLHI = 11'b00001111111;

    function automatic logic [31:0] rot32(input logic [31:0] t, input logic [4:0] s);
        logic [63:0] dbl;
        dbl = {t, t} << s;
        return dbl[63:32];
    endfunction

    function automatic logic [31:0] shl32(input logic [31:0] t, input logic [5:0] s);
        return (s > 6'd31) ? 32'd0 : (t << s[4:0]);
    endfunction

    function automatic logic [15:0] rot16(input logic [15:0] t, input logic [3:0] s);
        logic [31:0] dbl;
        dbl = {t, t} << s;
        return dbl[31:16];
    endfunction

    function automatic logic [15:0] shl16(input logic [15:0] t, input logic [4:0] s);
        return (s > 5'd15) ? 16'd0 : (t << s[3:0]);
    endfunction

    logic [10:0]        opcode;
    logic [6:0]         i7;
    logic               is_legal;
    logic               is_half;
    logic               is_shift;
    logic               is_imm;
    logic [0:WIDTH-1]   result;
    logic               stall;
    logic               unused_ok;

    assign opcode    = instruction[0:10];
    assign i7        = instruction[11:17];
    // Only the low count bits of each RB lane and of I7 matter after masking.
    assign unused_ok = ^{instruction[18:31], i7[6], RB_data_in};

    always_comb begin
        is_legal = 1'b1;
        is_half  = 1'b0;
        is_shift = 1'b0;
        is_imm   = 1'b0;
        case (opcode)
            OP_ROT:   ;
            OP_ROTI:  is_imm = 1'b1;
            OP_SHL:   is_shift = 1'b1;
            OP_SHLI:  begin is_shift = 1'b1; is_imm = 1'b1; end
            OP_ROTH:  is_half = 1'b1;
            OP_ROTHI: begin is_half = 1'b1; is_imm = 1'b1; end
            OP_SHLH:  begin is_half = 1'b1; is_shift = 1'b1; end
            OP_SHLHI: begin is_half = 1'b1; is_shift = 1'b1; is_imm = 1'b1; end
            default:  is_legal = 1'b0;
        endcase
    end

    // Lane slices are big-endian: the low count bits sit at the high index end.
    always_comb begin
        result = '0;
        if (is_legal && !is_half) begin
            for (int j = 0; j < NW; j++) begin
                if (is_shift)
                    result[32*j +: 32] = shl32(RA_data_in[32*j +: 32],
                                               is_imm ? i7[5:0] : RB_data_in[32*j+26 +: 6]);
                else
                    result[32*j +: 32] = rot32(RA_data_in[32*j +: 32],
                                               is_imm ? i7[4:0] : RB_data_in[32*j+27 +: 5]);
            end
        end else if (is_legal) begin
            for (int k = 0; k < NH; k++) begin
                if (is_shift)
                    result[16*k +: 16] = shl16(RA_data_in[16*k +: 16],
                                               is_imm ? i7[4:0] : RB_data_in[16*k+11 +: 5]);
                else
                    result[16*k +: 16] = rot16(RA_data_in[16*k +: 16],
                                               is_imm ? i7[3:0] : RB_data_in[16*k+12 +: 4]);
            end
        end
    end

    logic [1:LATENCY]   valid_q,   valid_d;
    logic [1:LATENCY]   illegal_q, illegal_d;
    logic [0:WIDTH-1]   data_q [1:LATENCY];
    logic [0:WIDTH-1]   data_d [1:LATENCY];
    logic [TAG_W-1:0]   tag_q  [1:LATENCY];
    logic [TAG_W-1:0]   tag_d  [1:LATENCY];

    assign stall       = valid_q[LATENCY] & ~out_ready;
    assign in_ready    = ~stall;
    assign out_valid   = valid_q[LATENCY];
    assign RT_data_out = data_q[LATENCY];
    assign out_tag     = tag_q[LATENCY];
    assign out_illegal = illegal_q[LATENCY];

    // Whole pipe freezes on stall; flush only clears valids and wins over everything.
    always_comb begin
        for (int s = 1; s <= LATENCY; s++) begin
            valid_d[s]   = valid_q[s];
            illegal_d[s] = illegal_q[s];
            data_d[s]    = data_q[s];
            tag_d[s]     = tag_q[s];
        end
        if (!stall) begin
            valid_d[1]   = in_valid;
            illegal_d[1] = ~is_legal;
            data_d[1]    = result;
            tag_d[1]     = in_tag;
            for (int s = 2; s <= LATENCY; s++) begin
                valid_d[s]   = valid_q[s-1];
                illegal_d[s] = illegal_q[s-1];
                data_d[s]    = data_q[s-1];
                tag_d[s]     = tag_q[s-1];
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            illegal_q <= '0;
            for (int s = 1; s <= LATENCY; s++) begin
                data_q[s] <= '0;
                tag_q[s]  <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            for (int s = 1; s <= LATENCY; s++) begin
                data_q[s] <= data_d[s];
                tag_q[s]  <= tag_d[s];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sf2_pipe.sv
// ============================================================================
// tb_sf2_pipe : directed stimulus with a lane/bit-level scoreboard model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sf2_pipe;

    localparam int WIDTH = 128;
    localparam int LAT   = 3;
    localparam int TAG_W = 7;

    localparam logic [10:0] OP_ROT   = 11'b00001011000;
    localparam logic [10:0] OP_ROTI  = 11'b00001111000;
    localparam logic [10:0] OP_SHL   = 11'b00001011011;
    localparam logic [10:0] OP_SHLI  = 11'b00001111011;
    localparam logic [10:0] OP_ROTH  = 11'b00001011100;
    localparam logic [10:0] OP_ROTHI = 11'b00001111100;
    localparam logic [10:0] OP_SHLH  = 11'b00001011111;
    localparam logic [10:0] OP_SHLHI = 11'b00001111111;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [0:31]        instruction;
    logic [0:WIDTH-1]   ra;
    logic [0:WIDTH-1]   rb;
    logic [TAG_W-1:0]   in_tag;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [0:WIDTH-1]   rt;
    logic [TAG_W-1:0]   out_tag;
    logic               out_illegal;

    sf2_pipe #(.WIDTH(WIDTH), .LATENCY(LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .RA_data_in(ra), .RB_data_in(rb), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .RT_data_out(rt), .out_tag(out_tag), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [0:31] mk(input logic [10:0] op, input logic [6:0] imm7);
        mk = {op, imm7, 14'd0};
    endfunction

    // Spec-level model: r[b] = t[(b+s) mod L] for rotates, t[b+s] or 0 for shifts.
    function automatic void model(input logic [0:31] ins, input logic [0:WIDTH-1] a,
                                  input logic [0:WIDTH-1] b,
                                  output logic [0:WIDTH-1] d, output logic ill);
        logic [10:0]        op;
        logic signed [6:0]  imm7;
        int                 L, mask, cnt, s;
        bit                 rotate, imm;
        op     = ins[0:10];
        imm7   = ins[11:17];
        d      = '0;
        ill    = 1'b0;
        L      = 32;
        mask   = 0;
        rotate = 1'b0;
        imm    = 1'b0;
        case (op)
            OP_ROT:   begin L = 32; rotate = 1; imm = 0; mask = 31; end
            OP_ROTI:  begin L = 32; rotate = 1; imm = 1; mask = 31; end
            OP_SHL:   begin L = 32; rotate = 0; imm = 0; mask = 63; end
            OP_SHLI:  begin L = 32; rotate = 0; imm = 1; mask = 63; end
            OP_ROTH:  begin L = 16; rotate = 1; imm = 0; mask = 15; end
            OP_ROTHI: begin L = 16; rotate = 1; imm = 1; mask = 15; end
            OP_SHLH:  begin L = 16; rotate = 0; imm = 0; mask = 31; end
            OP_SHLHI: begin L = 16; rotate = 0; imm = 1; mask = 31; end
            default:  ill = 1'b1;
        endcase
        if (!ill) begin
            for (int k = 0; k < WIDTH / L; k++) begin
                if (imm) begin
                    cnt = int'(imm7);
                end else begin
                    cnt = 0;
                    for (int bb = 0; bb < L; bb++) cnt = (cnt << 1) | int'(b[k*L+bb]);
                end
                s = cnt & mask;
                for (int bb = 0; bb < L; bb++) begin
                    if (rotate)
                        d[k*L+bb] = a[k*L + ((bb + s) % L)];
                    else
                        d[k*L+bb] = (bb + s < L) ? a[k*L+bb+s] : 1'b0;
                end
            end
        end
    endfunction

    typedef struct {
        logic [0:WIDTH-1] d;
        logic             ill;
        logic [TAG_W-1:0] tag;
        longint           adv;
    } exp_t;

    exp_t               sbq[$];
    longint             adv = 0;
    int                 retired = 0;
    logic               stall_prev = 1'b0;
    logic [0:WIDTH-1]   prev_rt;
    logic [TAG_W-1:0]   prev_tag;
    logic               prev_ill;

    // adv counts edges on which the pipe advanced; a result is due LAT advances after accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_rt", rt, prev_rt);
                chk("hold_tag", out_tag, prev_tag);
                chk("hold_ill", out_illegal, prev_ill);
            end
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("spurious_valid", out_valid, 1'b0);
                end else begin
                    chk("rt", rt, sbq[0].d);
                    chk("tag", out_tag, sbq[0].tag);
                    chk("illegal", out_illegal, sbq[0].ill);
                    chk("latency", adv - sbq[0].adv, LAT);
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        retired++;
                    end
                end
            end else if (sbq.size() != 0 && adv - sbq[0].adv >= LAT) begin
                chk("missing_result", out_valid, 1'b1);
            end
            if (in_valid && in_ready && !flush) begin
                exp_t e;
                logic [0:WIDTH-1] md;
                logic mi;
                model(instruction, ra, rb, md, mi);
                e.d   = md;
                e.ill = mi;
                e.tag = in_tag;
                e.adv = adv;
                sbq.push_back(e);
            end
            if (flush) sbq.delete();
            stall_prev = out_valid && !out_ready && !flush;
            prev_rt    = rt;
            prev_tag   = out_tag;
            prev_ill   = out_illegal;
            if (!(out_valid && !out_ready)) adv++;
        end
    end

    logic [TAG_W-1:0] tag_ctr = '0;

    task automatic send(input logic [0:31] ins, input logic [0:WIDTH-1] a, input logic [0:WIDTH-1] b);
        int  n;
        bit  acc;
        n           = 0;
        acc         = 0;
        in_valid    = 1'b1;
        instruction = ins;
        ra          = a;
        rb          = b;
        in_tag      = tag_ctr;
        tag_ctr     = tag_ctr + 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready && !flush;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_timeout", sbq.size(), 0);
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_valid", out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:WIDTH-1] md;
        logic             mi;
        logic [0:WIDTH-1] pat;
        int               r0;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        instruction = '0;
        ra          = '0;
        rb          = '0;
        in_tag      = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        pat         = 128'h0123456789ABCDEF_FEDCBA9876543210;

        // Hand-computed values pinning the model.
        model(mk(OP_ROTI, 7'd4), {4{32'h80000001}}, '0, md, mi);
        chk("pin_roti4", md, {4{32'h00000018}});
        model(mk(OP_ROTI, 7'h7F), {4{32'h00000001}}, '0, md, mi);
        chk("pin_roti_m1", md, {4{32'h80000000}});
        model(mk(OP_SHL, 7'd0), {4{32'hFFFFFFFF}}, {32'd0, 32'd1, 32'd31, 32'd32}, md, mi);
        chk("pin_shl", md, {32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000, 32'h00000000});
        model(mk(OP_ROTHI, 7'h7F), {8{16'h8001}}, '0, md, mi);
        chk("pin_rothi", md, {8{16'hC000}});
        model(mk(OP_SHLH, 7'd0), {8{16'hFFFF}}, {8{16'h0010}}, md, mi);
        chk("pin_shlh16", md, '0);
        model(32'h0, pat, pat, md, mi);
        chk("pin_illegal_d", md, '0);
        chk("pin_illegal_f", mi, 1'b1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_rt", rt, '0);
        chk("rst_tag", out_tag, '0);
        chk("rst_ill", out_illegal, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(mk(OP_ROTI, 7'd4), {4{32'h80000001}}, '0);
        send(mk(OP_ROTI, 7'h7F), {4{32'h00000001}}, '0);
        send(mk(OP_SHL, 7'd0), {4{32'hFFFFFFFF}}, {32'd0, 32'd1, 32'd31, 32'd32});
        send(mk(OP_ROTHI, 7'h7F), {8{16'h8001}}, '0);
        send(mk(OP_SHLH, 7'd0), {8{16'hFFFF}}, {8{16'h0010}});
        send(mk(OP_ROT, 7'd0), pat, {32'd5, 32'd37, 32'd0, 32'hFFFFFFFF});
        send(mk(OP_SHLI, 7'h40), pat, '0);
        send(mk(OP_SHLI, 7'h20), pat, '0);
        send(mk(OP_SHLI, 7'h7F), pat, '0);
        send(mk(OP_ROTH, 7'd0), pat, {16'd1, 16'd17, 16'd8, 16'd15, 16'd0, 16'hFFF0, 16'd4, 16'd12});
        send(mk(OP_SHLHI, 7'h0F), pat, '0);
        send(mk(OP_SHLH, 7'd0), pat, {16'd0, 16'd1, 16'd15, 16'd16, 16'd31, 16'd32, 16'd2, 16'd3});
        send(mk(OP_ROTHI, 7'h03), pat, '0);
        send(mk(11'b00001011001, 7'd5), pat, pat);
        drain();

        // Back-pressure: out_ready low for 3 cycles while streaming 6 ops.
        r0 = retired;
        fork
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 6; i++)
            send(mk((i % 2 == 0) ? OP_ROTI : OP_SHLHI, 7'(i + 1)), pat ^ {4{32'(i)}}, '0);
        drain();
        chk("bp_count", retired - r0, 6);

        // Reset with results in flight and one stalled at the output.
        out_ready = 1'b0;
        send(mk(OP_ROTI, 7'd8), {4{32'hDEADBEEF}}, '0);
        send(mk(OP_ROTI, 7'd9), {4{32'hDEADBEEF}}, '0);
        send(mk(OP_ROTI, 7'd10), {4{32'hDEADBEEF}}, '0);
        chk("pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_rt", rt, '0);
        chk("mid_rst_tag", out_tag, '0);
        chk("mid_rst_ill", out_illegal, 1'b0);
        sbq.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_check(LAT + 2);

        // Flush with the pipe full and stalled, plus an input in the flush cycle.
        out_ready = 1'b0;
        send(mk(OP_SHL, 7'd0), pat, {4{32'd3}});
        send(mk(OP_SHL, 7'd0), pat, {4{32'd4}});
        send(mk(OP_SHL, 7'd0), pat, {4{32'd5}});
        in_valid    = 1'b1;
        instruction = mk(OP_ROT, 7'd0);
        flush       = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle_check(LAT + 2);

        // Flush while flowing: the op presented with flush must be dropped.
        send(mk(OP_ROTH, 7'd0), pat, {8{16'd3}});
        in_valid    = 1'b1;
        instruction = mk(OP_ROTHI, 7'd2);
        flush       = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        idle_check(LAT + 2);

        r0 = retired;
        send(32'h0, pat, pat);
        drain();
        chk("illegal_count", retired - r0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sf2_pipe.md
# sf2_pipe

Pipelined, parametrised rotate/shift unit for the SPU-lite even pipe, the successor to the combinational simple-fixed-2 datapath. It executes word and halfword rotates and left shifts (register and 7-bit-immediate forms) across all lanes of a WIDTH-bit operand. Results emerge after LATENCY registered stages behind a valid/ready handshake with flush. It sits between the register-file read stage and the forwarding/writeback network.

## Interface
- WIDTH, 128, operand width in bits; multiple of 32; bit 0 is MSB; lanes are WIDTH/32 words or WIDTH/16 halfwords.
- LATENCY, 2, number of register stages from accept to out_valid; legal range 1..4.
- TAG_W, 7, width of the destination-register tag carried alongside data.

- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation present on inputs.
- in_ready  out  1  unit can accept this cycle.
- instruction  in  32 [0:31]  instruction word; opcode in bits 0:10, I7 in bits 11:17.
- RA_data_in  in  WIDTH [0:WIDTH-1]  source operand.
- RB_data_in  in  WIDTH [0:WIDTH-1]  per-lane count for RR forms.
- in_tag  in  TAG_W  destination tag.
- flush  in  1  kill all in-flight operations.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- RT_data_out  out  WIDTH [0:WIDTH-1]  result.
- out_tag  out  TAG_W  tag of result.
- out_illegal  out  1  opcode not recognised; RT_data_out is zero.

## Operation
- Decoded opcodes (bits 0:10): rot 00001011000, roti 00001111000, shl 00001011011, shli 00001111011, roth 00001011100, rothi 00001111100, shlh 00001011111, shlhi 00001111111.
- Count source: RR forms take the low bits of each lane's own RB slot (word: RB word j; halfword: RB halfword j). RI7 forms take I7 sign-extended to 32 bits, applied to every lane.
- Masks: rot/roti count & 0x1F; shl/shli count & 0x3F; roth/rothi count & 0x0F; shlh/shlhi count & 0x1F.
- Rotate (lane width L): r[b] = t[(b+s) mod L], i.e. rotate toward bit 0 (left).
- Shift left: r[b] = t[b+s] if b+s < L else 0; any count ≥ L yields lane = 0.
- Any other opcode: RT = 0, out_illegal = 1; it still occupies a slot and produces out_valid.
- Computation is combinational on the inputs and captured into stage 1; stages 2..LATENCY are pure delay registers for data, tag, illegal and valid.

## Timing
- Reset (rst_n low, asynchronous): all stage valids 0, out_valid 0, RT_data_out 0, out_tag 0, out_illegal 0. Reset mid-operation discards everything in flight.
- stall = out_valid & ~out_ready. in_ready = ~stall (combinational from out_ready).
- Accept when in_valid & in_ready; result appears with out_valid exactly LATENCY cycles later if no stall occurs.
- On stall, every stage holds (data, tag, valid); bubbles are not squeezed out.
- Output fields are stable while out_valid & ~out_ready.
- flush: all stage valids cleared at the next edge, regardless of stall; an input presented in the same cycle as flush is dropped (not accepted). Data registers need not clear. out_valid is 0 the cycle after flush.
- Throughput: one operation per cycle with out_ready held high.
- Simultaneous accept and output retire in one cycle are normal pipeline advance.

## Test plan
- Reset: assert rst_n low mid-stream with 2 ops in flight -> out_valid 0, RT 0, out_tag 0 immediately; no stale result after release.
- roti I7=4, RA words all 0x80000001 -> after LATENCY cycles every word 0x00000018; roti I7=0x7F (−1, count 31) on 0x00000001 -> 0x80000000.
- shl with RB words {0,1,31,32}, RA all 0xFFFFFFFF -> {0xFFFFFFFF, 0xFFFFFFFE, 0x80000000, 0x00000000}.
- rothi I7=0x7F (count 15), RA halfwords 0x8001 -> all 0xC000; shlh RB halfwords 0x0010 on 0xFFFF -> 0x0000.
- Back-pressure: stream 6 ops with out_ready low for 3 cycles mid-stream -> in_ready low during stall, outputs held stable, all 6 results in order with correct tags, no loss or duplication.
- Flush with LATENCY=3 and 3 ops in flight plus in_valid same cycle -> no out_valid for any of the 4; unknown opcode 0x000 afterward -> RT 0, out_illegal 1, out_valid 1.
